// File: rtl/adder_pkg.sv
// adder_pkg: default sizes and the pipeline stage record shared by pipelined_adder.
package adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;
  localparam int REC_WIDTH = DEF_WIDTH;
  typedef struct packed {
    logic valid;
    logic carry;
    logic cmsb;
    logic [REC_WIDTH-1:0] a;
    logic [REC_WIDTH-1:0] b;
    logic [REC_WIDTH-1:0] s;
  } stage_t;
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit ripple adder exposing the carry into its MSB.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);
  logic [W:0] c;
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[W];
  assign cmsb = c[W-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: CHUNK-bits-per-stage pipelined adder with valid/ready flow control.
// Define ADDER_SUB_EN to add the sub port (a + ~b + 1). WIDTH is limited to adder_pkg::REC_WIDTH.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0 || WIDTH > REC_WIDTH) begin : g_bad
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK, CHUNK <= WIDTH, WIDTH <= REC_WIDTH");
  end
  logic en;
  logic unused;
  stage_t in_rec, last;
  assign en = !last.valid || out_ready;
  assign in_ready = en;
  always_comb begin
    in_rec = '0;
    in_rec.valid = in_valid;
    in_rec.a[WIDTH-1:0] = a;
`ifdef ADDER_SUB_EN
    in_rec.b[WIDTH-1:0] = sub ? ~b : b;
    in_rec.carry = sub | cin;
`else
    in_rec.b[WIDTH-1:0] = b;
    in_rec.carry = cin;
`endif
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t src, nxt, r;
    logic [CHUNK-1:0] sum;
    logic co, cm;
    if (k == 0) begin : g_first
      assign src = in_rec;
    end else begin : g_next
      assign src = g_st[k-1].r;
    end
    adder_chunk #(.W(CHUNK)) u_chunk (
      .a(src.a[k*CHUNK +: CHUNK]),
      .b(src.b[k*CHUNK +: CHUNK]),
      .cin(src.carry),
      .s(sum),
      .cout(co),
      .cmsb(cm)
    );
    // everything not produced here rides along unchanged, including bubbles
    always_comb begin
      nxt = src;
      nxt.s[k*CHUNK +: CHUNK] = sum;
      nxt.carry = co;
      nxt.cmsb = cm;
    end
    always_ff @(posedge clk)
      if (rst) r <= '0;
      else if (en) r <= nxt;
  end
  assign last = g_st[STAGES-1].r;
  assign out_valid = last.valid;
  assign s = last.s[WIDTH-1:0];
  assign cout = last.carry;
  assign ovf = last.carry ^ last.cmsb;
  assign unused = ^last;
endmodule
